reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Four-requester round-robin arbiter for one shared 8-bit storage register (IDLE -> GRANT -> ACK).
// Define REG_ARB_PRIO0_EN to give requester 0 fixed priority over the round-robin group 1..3.
module reg_write_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [31:0] wdata,
   output logic [3:0]  grant,
   output logic [3:0]  ack,
   output logic [7:0]  q,
   output logic        busy,
   output logic [7:0]  wr_count
);

   typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

   // Declaration initialisers give the reset values at time zero in simulation.
   state_t      state    = IDLE;
   logic [1:0]  ptr      = '0;
   logic [1:0]  winner   = '0;
   logic [3:0]  grant_r  = '0;
   logic [3:0]  ack_r    = '0;
   logic [7:0]  q_r      = '0;
   logic [7:0]  count_r  = '0;

   state_t      state_next;
   logic [1:0]  ptr_next;
   logic [1:0]  winner_next;
   logic [3:0]  grant_next;
   logic [3:0]  ack_next;
   logic [7:0]  q_next;
   logic [7:0]  count_next;

   // First set bit at or above p, wrapping 3 -> 0.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [3:0] cand;
      logic [1:0] idx;
      logic [1:0] result;
      cand   = r;
`ifdef REG_ARB_PRIO0_EN
      cand   = {r[3:1], 1'b0};
`endif
      result = p;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (cand[idx]) result = idx;
      end
`ifdef REG_ARB_PRIO0_EN
      if (r[0]) result = 2'd0;
`endif
      return result;
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_next  = state;
      ptr_next    = ptr;
      winner_next = winner;
      grant_next  = '0;
      ack_next    = '0;
      q_next      = q_r;
      count_next  = count_r;
      case (state)
         IDLE: begin
            if (|req) begin
               winner_next = pick(req, ptr);
               grant_next  = 4'b0001 << pick(req, ptr);
               state_next  = GRANT;
            end
         end
         GRANT: begin
            if (req[winner]) begin
               q_next     = wdata[{winner, 3'b000} +: 8];
               ack_next   = 4'b0001 << winner;
               count_next = count_r + 8'd1;
               state_next = ACK;
            end else begin
               state_next = IDLE;
            end
         end
         ACK: begin
            ptr_next   = winner + 2'd1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         winner  <= '0;
         grant_r <= '0;
         ack_r   <= '0;
         q_r     <= '0;
         count_r <= '0;
      end else begin
         state   <= state_next;
         ptr     <= ptr_next;
         winner  <= winner_next;
         grant_r <= grant_next;
         ack_r   <= ack_next;
         q_r     <= q_next;
         count_r <= count_next;
      end
   end

   assign grant    = grant_r;
   assign ack      = ack_r;
   assign q        = q_r;
   assign busy     = (state != IDLE);
   assign wr_count = count_r;

endmodule
